cacheline_adaptor: RTL

Sits directly downstream of the cache, between its 256-bit physical-memory port and a 64-bit burst memory. Each line-fill or writeback becomes one 4-beat burst, beat 0 first. The cache sees a single line transaction closed by one `pmem_resp` pulse.

---
 rtl/cacheline_adaptor.sv | 106 ++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat burst memory.
// One line transaction maps to one burst; the cache sees a single pmem_resp pulse.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [31:0]  bmem_address,
    output logic [63:0]  bmem_wdata,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_resp
);
    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    typedef struct packed {
        logic [31:0]                   addr;
        logic [BEATS-1:0][BEAT_W-1:0]  line;
    } req_t;

    state_t                       state;
    logic [1:0]                   beat;
    req_t                         req;
    logic [BEATS-1:0][BEAT_W-1:0] rd_line;
    logic [1:0]                   beat_nxt;

    assign beat_nxt     = beat + 2'd1;
    assign bmem_address = req.addr;
    assign pmem_rdata   = rd_line;

    // Outputs are flops updated alongside the state, so the async reset
    // drops bmem_read/bmem_write at once and nothing depends on pmem_* combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat       <= 2'd0;
            req        <= '0;
            rd_line    <= '0;
            pmem_resp  <= 1'b0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    beat      <= 2'd0;
                    if (pmem_read) begin
                        req.addr  <= pmem_address & LINE_MASK;
                        bmem_read <= 1'b1;
                        state     <= RD_BURST;
                    end else if (pmem_write) begin
                        req.addr   <= pmem_address & LINE_MASK;
                        req.line   <= pmem_wdata;
                        bmem_write <= 1'b1;
                        bmem_wdata <= pmem_wdata[BEAT_W-1:0];
                        state      <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (bmem_resp) begin
                        rd_line[beat] <= bmem_rdata;
                        beat          <= beat_nxt;
                        if (beat == 2'd3) begin
                            bmem_read <= 1'b0;
                            pmem_resp <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_resp) begin
                        beat <= beat_nxt;
                        if (beat == 2'd3) begin
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            pmem_resp  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            bmem_wdata <= req.line[beat_nxt];
                        end
                    end
                end
                DONE: begin
                    pmem_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    pmem_resp  <= 1'b0;
                    bmem_read  <= 1'b0;
                    bmem_write <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
